async_clk_en_gen: RTL and testbench

- Synthesizable, parametrised successor to the behavioural multi-node clock/reset/send stimulus generator used by the NoC async benches.
- From one system clock it derives NUM_NODES independent divided node clocks, each with its own runtime-programmable period and phase.
- Each node clock also has a one-cycle rising-edge tick for use as a clock enable.
- A sequencer drives the node reset window, the send window and the cooldown window, then flags done; it can be restarted or aborted.

---
 rtl/async_gen_pkg.sv | 21 ++
 rtl/async_clk_div.sv | 53 +++++
 rtl/async_clk_en_gen.sv | 156 +++++++++++++++
 tb/tb_async_clk_en_gen.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_gen_pkg.sv
// Shared types and helpers for the divided node clock / sequence generator.
package async_gen_pkg;

  // Sequencer states: node reset window, traffic window, drain window, finished.
  typedef enum logic [2:0] {
    IDLE,
    RST,
    SEND,
    COOL,
    DONE
  } gen_state_t;

  // Smallest period that still yields one low and one high cycle.
  localparam int MIN_PERIOD = 2;

  // LSB of per-node field idx inside a flat bus of width-wide fields.
  function automatic int field_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/async_clk_div.sv
// One node clock channel: phase-loaded wrapping counter, divided clock and
// rising-edge tick. Outputs are registered from the next counter value, so
// node_clk/node_tick line up with the counter value held in the same cycle.
module async_clk_div
  import async_gen_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] phase,
  output logic             node_clk,
  output logic             node_tick,
  output logic             phase_ok
);

  logic [CNT_W-1:0] p_eff;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // Periods below two cannot form a clock, so they are stretched to two.
  assign p_eff    = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;
  assign half     = p_eff >> 1;
  assign phase_ok = (phase < p_eff);

  // Next counter value: phase load on start, wrap at p_eff-1 while running, else park at 0.
  always_comb begin
    cnt_nxt = '0;
    if (load) begin
      cnt_nxt = phase_ok ? phase : '0;
    end else if (run) begin
      cnt_nxt = (cnt >= p_eff - 1'b1) ? '0 : cnt + 1'b1;
    end
  end

  // Counter plus registered clock level and rising-edge tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      node_clk  <= 1'b0;
      node_tick <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      node_clk  <= (cnt_nxt >= half);
      node_tick <= (cnt_nxt == half);
    end
  end

endmodule

// File: rtl/async_clk_en_gen.sv
// Multi-node clock enable generator: a reset/send/cooldown sequencer plus
// NUM_NODES independently programmable divided clocks that free-run while
// the sequence is active and park low in IDLE and DONE.
module async_clk_en_gen
  import async_gen_pkg::*;
#(
  parameter int NUM_NODES       = 9,
  parameter int CNT_W           = 8,
  parameter int CYC_W           = 32,
  parameter int RESET_CYCLES    = 30,
  parameter int SIM_CYCLES      = 10000,
  parameter int COOLDOWN_CYCLES = 10000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_NODES*CNT_W-1:0] cfg_period,
  input  logic [NUM_NODES*CNT_W-1:0] cfg_phase,
  output logic [NUM_NODES-1:0]       node_clk,
  output logic [NUM_NODES-1:0]       node_tick,
  output logic                       node_reset,
  output logic                       send,
  output logic                       done,
  output logic                       cfg_err
);

  // Last cycle index of each window; a zero length still lasts one cycle.
  localparam logic [CYC_W-1:0] RST_LAST  =
    CYC_W'((RESET_CYCLES    == 0) ? 0 : RESET_CYCLES    - 1);
  localparam logic [CYC_W-1:0] SEND_LAST =
    CYC_W'((SIM_CYCLES      == 0) ? 0 : SIM_CYCLES      - 1);
  localparam logic [CYC_W-1:0] COOL_LAST =
    CYC_W'((COOLDOWN_CYCLES == 0) ? 0 : COOLDOWN_CYCLES - 1);

  gen_state_t                       state;
  logic [CYC_W-1:0]                 cyc;
  logic [NUM_NODES-1:0][CNT_W-1:0]  period_q;
  logic [NUM_NODES-1:0]             phase_ok;
  logic                             accept;
  logic                             run;
  logic                             last;

  // start only counts from a resting state and loses to abort.
  assign accept = start && !abort && ((state == IDLE) || (state == DONE));

  // Final cycle of the current timed window.
  always_comb begin
    last = 1'b0;
    case (state)
      RST:     last = (cyc == RST_LAST);
      SEND:    last = (cyc == SEND_LAST);
      COOL:    last = (cyc == COOL_LAST);
      default: last = 1'b0;
    endcase
  end

  // Node counters advance whenever the next state is RST, SEND or COOL.
  assign run = !abort &&
               ((state == RST) || (state == SEND) || ((state == COOL) && !last));

  // Sequencer with outputs registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cyc        <= '0;
      node_reset <= 1'b1;
      send       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      cyc        <= '0;
      node_reset <= 1'b1;
      send       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RST;
            cyc        <= '0;
            node_reset <= 1'b1;
            send       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= ~&phase_ok;
          end
        end
        RST: begin
          if (last) begin
            state      <= SEND;
            cyc        <= '0;
            node_reset <= 1'b0;
            send       <= 1'b1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        SEND: begin
          if (last) begin
            state <= COOL;
            cyc   <= '0;
            send  <= 1'b0;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        COOL: begin
          if (last) begin
            state <= DONE;
            cyc   <= '0;
            done  <= 1'b1;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Period snapshot taken on an accepted start. The flat bus and the packed
  // array share layout, so node i lands in period_q[i]. Phase is only needed
  // on the load cycle itself, so it is consumed directly and never stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '0;
    end else if (accept) begin
      period_q <= cfg_period;
    end
  end

  for (genvar i = 0; i < NUM_NODES; i++) begin : g_node
    localparam int LSB = field_lsb(i, CNT_W);
    logic [CNT_W-1:0] period_sel;

    // On the load cycle the live period is what gets captured, so use it for
    // the phase check and the first clock level; afterwards use the snapshot.
    assign period_sel = accept ? cfg_period[LSB +: CNT_W] : period_q[i];

    async_clk_div #(
      .CNT_W(CNT_W)
    ) u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .run      (run),
      .period   (period_sel),
      .phase    (cfg_phase[LSB +: CNT_W]),
      .node_clk (node_clk[i]),
      .node_tick(node_tick[i]),
      .phase_ok (phase_ok[i])
    );
  end

endmodule

// File: tb/tb_async_clk_en_gen.sv
// Bench for async_clk_en_gen: a behavioural model pushes the expected output
// vector for every driven cycle; each scenario task pops and compares it,
// and adds direct checks of the cycle numbers the sequence must hit.
module tb_async_clk_en_gen;

  localparam int N  = 3;
  localparam int CW = 8;
  localparam int RC = 4;
  localparam int SC = 20;
  localparam int CC = 8;

  localparam int PE[N]         = '{6, 4, 4};
  localparam int HE[N]         = '{3, 2, 2};
  localparam int FIRST_RISE[N] = '{4, 3, 2};

  typedef enum int {M_IDLE, M_RST, M_SEND, M_COOL, M_DONE} mst_t;

  typedef struct packed {
    logic [N-1:0] nclk;
    logic [N-1:0] ntick;
    logic         nrst;
    logic         snd;
    logic         dn;
    logic         err;
  } obs_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [N*CW-1:0] cfg_period = '0;
  logic [N*CW-1:0] cfg_phase = '0;
  logic [N-1:0]    node_clk;
  logic [N-1:0]    node_tick;
  logic            node_reset;
  logic            send;
  logic            done;
  logic            cfg_err;

  obs_t got;
  obs_t exp_o;
  obs_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model state
  mst_t ms = M_IDLE;
  int   mn = 0;
  int   mt = 0;
  int   mp[N];
  int   mph[N];
  logic merr = 1'b0;

  always #5 clk = ~clk;

  async_clk_en_gen #(
    .NUM_NODES(N),
    .CNT_W(CW),
    .CYC_W(32),
    .RESET_CYCLES(RC),
    .SIM_CYCLES(SC),
    .COOLDOWN_CYCLES(CC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_period(cfg_period),
    .cfg_phase (cfg_phase),
    .node_clk  (node_clk),
    .node_tick (node_tick),
    .node_reset(node_reset),
    .send      (send),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  assign got = {node_clk, node_tick, node_reset, send, done, cfg_err};

  function automatic int fld(input logic [N*CW-1:0] bus, input int i);
    return int'(bus[i*CW +: CW]);
  endfunction

  task automatic set_cfg(input int p0, p1, p2, f0, f1, f2);
    cfg_period = {CW'(p2), CW'(p1), CW'(p0)};
    cfg_phase  = {CW'(f2), CW'(f1), CW'(f0)};
  endtask

  // Drive one cycle of inputs, advance the model, queue its expectation,
  // then wait until just after the edge so outputs are stable.
  task automatic drive(input logic r, input logic a, input logic s);
    obs_t e;
    int   c;
    int   p;
    int   f;
    logic running;
    reset = r;
    abort = a;
    start = s;
    if (r) begin
      ms = M_IDLE; mn = 0; mt = 0; merr = 1'b0;
    end else if (a) begin
      ms = M_IDLE; mn = 0; mt = 0;
    end else if (s && (ms == M_IDLE || ms == M_DONE)) begin
      ms = M_RST; mn = 0; mt = 0; merr = 1'b0;
      for (int i = 0; i < N; i++) begin
        p = fld(cfg_period, i);
        if (p < 2) p = 2;
        f = fld(cfg_phase, i);
        if (f >= p) begin
          f    = 0;
          merr = 1'b1;
        end
        mp[i]  = p;
        mph[i] = f;
      end
    end else begin
      case (ms)
        M_RST:  begin mn++; mt++; if (mn == RC) begin ms = M_SEND; mn = 0; end end
        M_SEND: begin mn++; mt++; if (mn == SC) begin ms = M_COOL; mn = 0; end end
        M_COOL: begin mn++; mt++; if (mn == CC) begin ms = M_DONE; mn = 0; end end
        default: ;
      endcase
    end
    running = (ms == M_RST) || (ms == M_SEND) || (ms == M_COOL);
    for (int i = 0; i < N; i++) begin
      c = running ? (mph[i] + mt) % mp[i] : 0;
      e.nclk[i]  = running && (c >= mp[i] / 2);
      e.ntick[i] = running && (c == mp[i] / 2);
    end
    e.nrst = (ms == M_IDLE) || (ms == M_RST);
    e.snd  = (ms == M_SEND);
    e.dn   = (ms == M_DONE);
    e.err  = merr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(k < 2, 1'b0, 1'b0);
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL reset_sb cyc=%0d got=%b exp=%b", cyc, got, exp_o);
      end
    end
    n_cmp++;
    if (node_reset !== 1'b1 || {node_clk, node_tick, send, done, cfg_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_vals got=%b exp nrst=1 rest=0", got);
    end
  endtask

  task automatic test_sequence();
    int           s;
    int           rel;
    int           first_rise[N];
    int           rise_at[N];
    int           fall_at[N];
    int           send_n;
    int           send_first;
    int           done_first;
    logic [N-1:0] prev;
    set_cfg(6, 4, 4, 0, 0, 1);
    send_n = 0; send_first = -1; done_first = -1; prev = '0;
    for (int i = 0; i < N; i++) begin
      first_rise[i] = -1; rise_at[i] = 0; fall_at[i] = 0;
    end
    s = cyc;
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'b0, k == 0);
      rel = cyc - s;
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL seq_sb rel=%0d got=%b exp=%b", rel, got, exp_o);
      end
      if (send === 1'b1) begin
        send_n++;
        if (send_first < 0) send_first = rel;
      end
      if (done === 1'b1 && done_first < 0) done_first = rel;
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (node_tick[i] !== (node_clk[i] && !prev[i])) begin
          n_bad++;
          $display("FAIL tick_align node=%0d rel=%0d got=%b exp=%b", i, rel,
                   node_tick[i], node_clk[i] && !prev[i]);
        end
        if (node_clk[i] && !prev[i]) begin
          if (first_rise[i] < 0) begin
            first_rise[i] = rel;
          end else begin
            n_cmp++;
            if (rel - fall_at[i] != HE[i]) begin
              n_bad++;
              $display("FAIL low_time node=%0d got=%0d exp=%0d", i, rel - fall_at[i], HE[i]);
            end
          end
          rise_at[i] = rel;
        end
        if (!node_clk[i] && prev[i] && done !== 1'b1) begin
          n_cmp++;
          if (rel - rise_at[i] != PE[i] - HE[i]) begin
            n_bad++;
            $display("FAIL high_time node=%0d got=%0d exp=%0d", i, rel - rise_at[i], PE[i] - HE[i]);
          end
          fall_at[i] = rel;
        end
        prev[i] = node_clk[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (first_rise[i] != FIRST_RISE[i]) begin
        n_bad++;
        $display("FAIL first_rise node=%0d got=%0d exp=%0d", i, first_rise[i], FIRST_RISE[i]);
      end
    end
    n_cmp++;
    if (send_first != 5 || send_n != SC) begin
      n_bad++;
      $display("FAIL send_window first=%0d n=%0d exp first=5 n=%0d", send_first, send_n, SC);
    end
    n_cmp++;
    if (done_first != 33 || done !== 1'b1 || node_clk !== '0) begin
      n_bad++;
      $display("FAIL done_entry first=%0d done=%b clk=%b exp 33/1/000", done_first, done, node_clk);
    end
  endtask

  task automatic test_period_edges();
    int           s;
    int           rel;
    int           ticks;
    int           highs;
    logic [N-1:0] prev;
    set_cfg(5, 0, 1, 0, 0, 0);
    ticks = 0; highs = 0; prev = '0;
    s = cyc;
    for (int k = 0; k < 25; k++) begin
      drive(1'b0, 1'b0, k == 0);
      rel = cyc - s;
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL edge_sb rel=%0d got=%b exp=%b", rel, got, exp_o);
      end
      if (node_tick[0] === 1'b1) ticks++;
      if (node_clk[0] === 1'b1) highs++;
      if (rel >= 2) begin
        for (int i = 1; i < N; i++) begin
          n_cmp++;
          if (node_clk[i] === prev[i]) begin
            n_bad++;
            $display("FAIL short_period node=%0d rel=%0d got=%b exp=%b", i, rel, node_clk[i], ~prev[i]);
          end
        end
      end
      prev = node_clk;
    end
    n_cmp++;
    if (ticks != 5 || highs != 15) begin
      n_bad++;
      $display("FAIL period5 ticks=%0d highs=%0d exp 5/15", ticks, highs);
    end
    drive(1'b0, 1'b1, 1'b0);
    exp_o = sb.pop_front();
    n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL edge_abort_sb got=%b exp=%b", got, exp_o);
    end
  endtask

  task automatic test_phase();
    set_cfg(4, 4, 4, 3, 4, 0);
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 1'b0, k == 0);
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL phase_sb cyc=%0d got=%b exp=%b", cyc, got, exp_o);
      end
      if (k == 0) begin
        n_cmp++;
        if (cfg_err !== 1'b1 || node_clk[0] !== 1'b1) begin
          n_bad++;
          $display("FAIL phase_load err=%b clk0=%b exp 1/1", cfg_err, node_clk[0]);
        end
      end
      n_cmp++;
      if (node_clk[1] !== node_clk[2]) begin
        n_bad++;
        $display("FAIL phase_clamp cyc=%0d got=%b exp=%b", cyc, node_clk[1], node_clk[2]);
      end
    end
    drive(1'b0, 1'b1, 1'b0);
    exp_o = sb.pop_front();
    n_cmp++;
    if (got !== exp_o || cfg_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky got=%b exp=%b", got, exp_o);
    end
  endtask

  task automatic test_abort();
    set_cfg(6, 4, 4, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, k == 0);
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL abort_sb cyc=%0d got=%b exp=%b", cyc, got, exp_o);
      end
      if (k == 0) begin
        n_cmp++;
        if (cfg_err !== 1'b0) begin
          n_bad++;
          $display("FAIL err_clear got=%b exp=0", cfg_err);
        end
      end
    end
    drive(1'b0, 1'b1, 1'b0);
    exp_o = sb.pop_front();
    n_cmp++;
    if (got !== exp_o || send !== 1'b0 || node_reset !== 1'b1 || node_clk !== '0) begin
      n_bad++;
      $display("FAIL abort_idle got=%b exp=%b", got, exp_o);
    end
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, k == 0, k == 0);
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL abort_start_sb cyc=%0d got=%b exp=%b", cyc, got, exp_o);
      end
    end
    n_cmp++;
    if (node_clk !== '0 || send !== 1'b0 || done !== 1'b0 || node_reset !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_start_idle got=%b exp clk=0 nrst=1", got);
    end
  endtask

  task automatic test_restart();
    int ticks;
    int k;
    set_cfg(6, 4, 4, 0, 0, 1);
    for (int j = 0; j < 12; j++) begin
      drive(1'b0, 1'b0, j == 0);
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL restart_a_sb cyc=%0d got=%b exp=%b", cyc, got, exp_o);
      end
    end
    set_cfg(5, 3, 8, 0, 1, 2);
    drive(1'b0, 1'b0, 1'b1);
    exp_o = sb.pop_front();
    n_cmp++;
    if (got !== exp_o || send !== 1'b1) begin
      n_bad++;
      $display("FAIL start_in_send got=%b exp=%b", got, exp_o);
    end
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      drive(1'b0, 1'b0, 1'b0);
      k++;
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL restart_run_sb cyc=%0d got=%b exp=%b", cyc, got, exp_o);
      end
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_done got=%b exp=1 after %0d cycles", done, k);
    end
    ticks = 0;
    for (int j = 0; j < 20; j++) begin
      drive(1'b0, 1'b0, j == 0);
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL restart_b_sb cyc=%0d got=%b exp=%b", cyc, got, exp_o);
      end
      if (j == 0) begin
        n_cmp++;
        if (node_reset !== 1'b1 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL restart nrst=%b done=%b exp 1/0", node_reset, done);
        end
      end
      if (node_tick[0] === 1'b1) ticks++;
    end
    n_cmp++;
    if (ticks != 4) begin
      n_bad++;
      $display("FAIL new_cfg_ticks got=%0d exp=4", ticks);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    drive(1'b0, 1'b1, 1'b0);
    exp_o = sb.pop_front();
    n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL rm_abort_sb got=%b exp=%b", got, exp_o);
    end
    set_cfg(6, 4, 4, 0, 9, 0);
    drive(1'b0, 1'b0, 1'b1);
    exp_o = sb.pop_front();
    n_cmp++;
    if (got !== exp_o || cfg_err !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_err_set got=%b exp=%b", got, exp_o);
    end
    k = 0;
    while (!(node_reset === 1'b0 && send === 1'b0) && k < 50) begin
      drive(1'b0, 1'b0, 1'b0);
      k++;
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o) begin
        n_bad++;
        $display("FAIL rm_run_sb cyc=%0d got=%b exp=%b", cyc, got, exp_o);
      end
    end
    n_cmp++;
    if (node_reset !== 1'b0 || send !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_cool got=%b exp cool after %0d cycles", got, k);
    end
    drive(1'b0, 1'b0, 1'b0);
    exp_o = sb.pop_front();
    n_cmp++;
    if (got !== exp_o) begin
      n_bad++;
      $display("FAIL rm_cool_sb got=%b exp=%b", got, exp_o);
    end
    drive(1'b1, 1'b0, 1'b1);
    exp_o = sb.pop_front();
    n_cmp++;
    if (got !== exp_o || node_reset !== 1'b1 || cfg_err !== 1'b0 ||
        {node_clk, node_tick, send, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid got=%b exp=%b", got, exp_o);
    end
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b0, 1'b0);
      exp_o = sb.pop_front();
      n_cmp++;
      if (got !== exp_o || node_clk !== '0) begin
        n_bad++;
        $display("FAIL post_reset_idle cyc=%0d got=%b exp=%b", cyc, got, exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_period_edges();
    test_phase();
    test_abort();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
